// File: rtl/fetch_unit.sv
// fetch_unit: program counter and fetch stage in front of a combinational-read
// instruction memory. The fetched word and its PC are registered and offered to
// decode with a valid/ready handshake. Supports sequential advance, redirect
// with flush, back-pressure stall, and sticky faults on misaligned or
// out-of-range fetch addresses.
// Optional feature macro: FETCH_PERF_EN adds the perf_fetch_cnt and
// perf_stall_cnt counters.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_WORDS = 128
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc_plus4,
`ifdef FETCH_PERF_EN
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt,
`endif
   output logic        fault
);

   typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

   // One bit wider than the PC so the limit itself never overflows.
   localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) << 2;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_instr_q, out_instr_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic        fault_q, fault_d;
   logic        load, pc_legal, legal_load;

   assign load     = (state_q == RUN) && (!out_valid_q || out_ready);
   assign pc_legal = (pc_q[1:0] == 2'b00) && ({1'b0, pc_q} < PC_LIMIT);

   // Next-state logic: a redirect in RUN beats loading, and loading beats holding.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;
      fault_d     = fault_q;
      legal_load  = 1'b0;
      case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (redirect_valid) begin
               pc_d        = redirect_target;
               out_valid_d = 1'b0;
            end else if (load) begin
               if (pc_legal) begin
                  legal_load  = 1'b1;
                  out_instr_d = imem_data;
                  out_pc_d    = pc_q;
                  out_valid_d = 1'b1;
                  pc_d        = pc_q + 32'd4;
               end else begin
                  out_valid_d = 1'b0;
                  fault_d     = 1'b1;
                  state_d     = FAULT;
               end
            end
         end
         FAULT: begin
            // A still-pending output drains once; nothing new is ever fetched.
            if (out_ready) out_valid_d = 1'b0;
         end
         default: state_d = BOOT;
      endcase
   end

   // State and datapath registers; reset overrides any stall or redirect.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= BOOT;
         pc_q        <= RESET_PC;
         out_valid_q <= 1'b0;
         out_instr_q <= 32'd0;
         out_pc_q    <= 32'd0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
         fault_q     <= fault_d;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_q, perf_stall_q;

   // Performance counters: legal loads and back-pressured cycles, wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetch_q <= 32'd0;
         perf_stall_q <= 32'd0;
      end else begin
         if (legal_load) perf_fetch_q <= perf_fetch_q + 32'd1;
         if (out_valid_q && !out_ready) perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_fetch_cnt = perf_fetch_q;
   assign perf_stall_cnt = perf_stall_q;
`endif

   assign imem_addr    = pc_q;
   assign out_valid    = out_valid_q;
   assign out_instr    = out_instr_q;
   assign out_pc       = out_pc_q;
   assign out_pc_plus4 = out_pc_q + 32'd4;
   assign fault        = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: boot latency, sequential fetch, stall,
// redirect flush, range and alignment faults, and reset recovery.
// The perf counters are exercised when FETCH_PERF_EN is defined.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;
   logic        fault;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Instruction memory model: word i holds 32'hC0DE_0000 + i.
   logic [31:0] mem [0:127];
   assign imem_data = (imem_addr < 32'd512) ? mem[imem_addr[8:2]] : 32'hBAD0_BAD0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(128)) dut (
      .clk(clk),
      .reset(reset),
      .imem_addr(imem_addr),
      .imem_data(imem_data),
      .redirect_valid(redirect_valid),
      .redirect_target(redirect_target),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_instr(out_instr),
      .out_pc(out_pc),
      .out_pc_plus4(out_pc_plus4),
`ifdef FETCH_PERF_EN
      .perf_fetch_cnt(perf_fetch_cnt),
      .perf_stall_cnt(perf_stall_cnt),
`endif
      .fault(fault)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one rising edge, then settle so outputs are sampled away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
      reset = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0;

      // Reset state
      tick();
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_fault", {31'd0, fault}, 32'd0);
      check("rst_pc", out_pc, 32'h0);
      check("rst_instr", out_instr, 32'h0);
      check("rst_addr", imem_addr, 32'h0);

      // Sequential fetch: BOOT edge, then first valid on the 2nd edge
      reset = 1'b0;
      tick();
      check("boot_valid", {31'd0, out_valid}, 32'd0);
      tick();
      check("f0_valid", {31'd0, out_valid}, 32'd1);
      check("f0_pc", out_pc, 32'h0);
      check("f0_instr", out_instr, 32'hC0DE_0000);
      check("f0_plus4", out_pc_plus4, 32'h4);
      tick();
      check("f1_pc", out_pc, 32'h4);
      check("f1_instr", out_instr, 32'hC0DE_0001);
      tick();
      check("f2_pc", out_pc, 32'h8);
      check("f2_instr", out_instr, 32'hC0DE_0002);
      tick();
      check("f3_pc", out_pc, 32'hC);
      check("f3_instr", out_instr, 32'hC0DE_0003);
      check("f3_plus4", out_pc_plus4, 32'h10);

      // Redirect back to 4 so that (4,B) is the pending output, then stall
      redirect_valid = 1'b1; redirect_target = 32'h4;
      tick();
      redirect_valid = 1'b0;
      check("rd4_valid", {31'd0, out_valid}, 32'd0);
      check("rd4_addr", imem_addr, 32'h4);
      tick();
      check("rd4_pc", out_pc, 32'h4);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_valid", {31'd0, out_valid}, 32'd1);
         check("stall_pc", out_pc, 32'h4);
         check("stall_instr", out_instr, 32'hC0DE_0001);
         check("stall_addr", imem_addr, 32'h8);
      end
      out_ready = 1'b1;
      tick();
      check("rel_pc", out_pc, 32'h8);
      check("rel_instr", out_instr, 32'hC0DE_0002);

      // Redirect during a stall flushes the pending output
      out_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h40;
      tick();
      redirect_valid = 1'b0; out_ready = 1'b1;
      check("rd40_valid", {31'd0, out_valid}, 32'd0);
      check("rd40_addr", imem_addr, 32'h40);
      tick();
      check("rd40_out_valid", {31'd0, out_valid}, 32'd1);
      check("rd40_pc", out_pc, 32'h40);
      check("rd40_instr", out_instr, 32'hC0DE_0010);

      // Last legal word, then an out-of-range fault
      redirect_valid = 1'b1; redirect_target = 32'h1FC;
      tick();
      redirect_valid = 1'b0;
      check("rd1fc_valid", {31'd0, out_valid}, 32'd0);
      tick();
      check("last_pc", out_pc, 32'h1FC);
      check("last_instr", out_instr, 32'hC0DE_007F);
      check("last_addr", imem_addr, 32'h200);
      tick();
      check("oor_fault", {31'd0, fault}, 32'd1);
      check("oor_valid", {31'd0, out_valid}, 32'd0);
      check("oor_addr", imem_addr, 32'h200);
      check("oor_pc_hold", out_pc, 32'h1FC);
      redirect_valid = 1'b1; redirect_target = 32'h0;
      tick();
      redirect_valid = 1'b0;
      check("flt_rd_ignored", imem_addr, 32'h200);
      check("flt_sticky", {31'd0, fault}, 32'd1);
      check("flt_valid", {31'd0, out_valid}, 32'd0);

      // Reset clears the fault; a redirect during BOOT is ignored
      reset = 1'b1;
      tick();
      check("rst2_fault", {31'd0, fault}, 32'd0);
      check("rst2_addr", imem_addr, 32'h0);
      reset = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h80;
      tick();
      redirect_valid = 1'b0;
      check("boot_rd_ignored", imem_addr, 32'h0);

      // Misaligned redirect target faults on the next load attempt
      redirect_valid = 1'b1; redirect_target = 32'h6;
      tick();
      redirect_valid = 1'b0;
      check("mis_addr", imem_addr, 32'h6);
      check("mis_fault_pre", {31'd0, fault}, 32'd0);
      tick();
      check("mis_fault", {31'd0, fault}, 32'd1);
      check("mis_valid", {31'd0, out_valid}, 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst3_fault", {31'd0, fault}, 32'd0);
      tick();
      tick();
      check("rst3_valid", {31'd0, out_valid}, 32'd1);
      check("rst3_pc", out_pc, 32'h0);
      check("rst3_instr", out_instr, 32'hC0DE_0000);

`ifdef FETCH_PERF_EN
      // Perf counters: 5 accepted loads plus 2 stall cycles
      reset = 1'b1;
      tick();
      check("perf_rst_fetch", perf_fetch_cnt, 32'd0);
      check("perf_rst_stall", perf_stall_cnt, 32'd0);
      reset = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) tick();
      out_ready = 1'b0;
      tick();
      tick();
      check("perf_fetch", perf_fetch_cnt, 32'd5);
      check("perf_stall", perf_stall_cnt, 32'd2);
      out_ready = 1'b1;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
